kmeans_argmin_select: RTL and testbench
=======================================

Name: kmeans_argmin_select

Overview:
- Sequential nearest-centroid selector for the K-means datapath.
- Consumes a stream of K distances per data point, one per cluster in index order (cluster 0 first).
- Keeps a running minimum with a magnitude compare, then emits the winning cluster index and its distance over a valid/ready handshake.
- Sits between the distance-computation stage and the cluster-assignment/accumulate stage.

Parameters:
- DIST_W, 64, width of each unsigned distance.
- NUM_CLUSTERS, 4, distances per point (K); legal range 1..256.
- IDX_W, 2, width of the cluster index; must satisfy 2**IDX_W >= NUM_CLUSTERS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_dist is valid
- in_ready  output  1  block accepts a distance this cycle
- in_dist  input  DIST_W  unsigned distance for the current cluster index
- out_valid  output  1  result is valid
- out_ready  input  1  downstream accepts the result
- out_idx  output  IDX_W  index of the minimum distance
- out_min_dist  output  DIST_W  minimum distance value

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset forces all of the following:
  - state=ACCUM, cnt=0, best_dist=0, best_idx=0.
  - out_valid=0, out_idx=0, out_min_dist=0, in_ready=1.
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.
- State ACCUM (in_ready=1, out_valid=0):
  - On each transfer with cnt==0: best_dist<=in_dist, best_idx<=0.
  - On each transfer with cnt>0: if in_dist < best_dist (unsigned, strict), then best_dist<=in_dist and best_idx<=cnt.
  - Ties keep the earlier index, so the lowest index wins.
  - cnt increments on each transfer.
  - On the transfer where cnt==NUM_CLUSTERS-1: cnt<=0 and next state is HOLD.
  - No transfer: all state holds.
- State HOLD (in_ready=0, out_valid=1):
  - out_idx and out_min_dist drive best_idx and best_dist, and stay stable until the output transfer.
  - On the output transfer: next state is ACCUM, out_valid falls next cycle.
- Latency:
  - out_valid asserts the cycle after the last distance is accepted.
  - After the output transfer, in_ready reasserts the cycle after. There is one mandatory bubble per point and no input/output overlap.
- Boundary conditions:
  - NUM_CLUSTERS=1: every accepted distance produces a result with idx 0.
  - All-equal distances give idx 0.
  - Distance 2**DIST_W-1 is legal; there is no overflow because no arithmetic beyond compare is done.
- in_valid gaps between distances of the same point are allowed; the count is preserved.
- out_ready held low keeps HOLD indefinitely. Inputs are ignored because in_ready=0.
- rst_n asserted mid-point or in HOLD discards the partial or pending result immediately. The first distance after release is cluster 0.
- cnt width is IDX_W and never exceeds NUM_CLUSTERS-1.

Optional Feature:
- Macro: ARGMIN_TIE_FLAG_EN.
- Defined:
  - Adds output port out_tie (1 bit, reset 0).
  - out_tie=1 in HOLD when the final minimum value was presented by two or more clusters of that point.
  - Tracking: set the internal tie bit on in_dist==best_dist with cnt>0. Clear it on a strict new minimum and on cnt==0.
  - out_tie is valid with out_valid.
- Undefined: the port and the tie logic are absent; all other behaviour is identical.

Test Plan:
- K=4, distances 40,12,30,25 back-to-back, out_ready=1 -> out_valid 1 cycle after the 4th accept, out_idx=1, out_min_dist=12, in_ready=0 for exactly 1 cycle.
- K=4, distances 7,7,3,3 -> out_idx=2, out_min_dist=3; with ARGMIN_TIE_FLAG_EN, out_tie=1. Then 9,5,8,6 -> out_idx=1, out_tie=0.
- K=4, distances 0xFFFF_FFFF_FFFF_FFFF ×3 then 0xFFFF_FFFF_FFFF_FFFE -> out_idx=3.
- out_ready held 0 for 10 cycles after the result -> out_valid, out_idx, out_min_dist stable, in_ready=0, and in_valid pulses ignored. out_ready=1 -> the next point starts at cluster 0.
- Random in_valid gaps (2-cycle gaps between distances 50,60,10,20) -> out_idx=2 and the cycle count matches accepts only.
- rst_n pulsed low after 2 of 4 distances -> outputs 0 and in_ready=1 immediately. The next 4 distances 5,4,3,9 -> out_idx=2.

Source files
------------

// File: rtl/kmeans_argmin_select.sv
// Nearest-centroid selector: running unsigned min over K distances per point.
// Optional ARGMIN_TIE_FLAG_EN adds out_tie (minimum shared by 2+ clusters).
module kmeans_argmin_select #(
   parameter int DIST_W       = 64,
   parameter int NUM_CLUSTERS = 4,
   parameter int IDX_W        = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIST_W-1:0] in_dist,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
`ifdef ARGMIN_TIE_FLAG_EN
   output logic              out_tie,
`endif
   output logic [DIST_W-1:0] out_min_dist
);

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLUSTERS - 1);

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [DIST_W-1:0] best_dist_q, best_dist_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
`ifdef ARGMIN_TIE_FLAG_EN
   logic              tie_q, tie_d;
`endif

   logic in_xfer;
   logic out_xfer;

   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_HOLD);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Result buses read zero outside HOLD so partial minima never leak.
   assign out_idx      = out_valid ? best_idx_q  : '0;
   assign out_min_dist = out_valid ? best_dist_q : '0;
`ifdef ARGMIN_TIE_FLAG_EN
   assign out_tie      = out_valid ? tie_q : 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      best_dist_d = best_dist_q;
      best_idx_d  = best_idx_q;
`ifdef ARGMIN_TIE_FLAG_EN
      tie_d       = tie_q;
`endif
      case (state_q)
         ST_ACCUM: begin
            if (in_xfer) begin
               if (cnt_q == '0) begin
                  best_dist_d = in_dist;
                  best_idx_d  = '0;
`ifdef ARGMIN_TIE_FLAG_EN
                  tie_d       = 1'b0;
`endif
               end else if (in_dist < best_dist_q) begin
                  // Strict compare: ties keep the lower index.
                  best_dist_d = in_dist;
                  best_idx_d  = cnt_q;
`ifdef ARGMIN_TIE_FLAG_EN
                  tie_d       = 1'b0;
`endif
               end
`ifdef ARGMIN_TIE_FLAG_EN
               else if (in_dist == best_dist_q) begin
                  tie_d = 1'b1;
               end
`endif
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (out_xfer) begin
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         cnt_q       <= '0;
         best_dist_q <= '0;
         best_idx_q  <= '0;
`ifdef ARGMIN_TIE_FLAG_EN
         tie_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         best_dist_q <= best_dist_d;
         best_idx_q  <= best_idx_d;
`ifdef ARGMIN_TIE_FLAG_EN
         tie_q       <= tie_d;
`endif
      end
   end

endmodule

// File: tb/tb_kmeans_argmin_select.sv
// Directed bench for kmeans_argmin_select (K=4 main DUT plus a K=1 instance).
module tb_kmeans_argmin_select;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_dist;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_idx;
   logic [63:0] out_min_dist;
`ifdef ARGMIN_TIE_FLAG_EN
   logic        out_tie;
   logic        k1_out_tie;
`endif

   logic        k1_in_valid;
   logic        k1_in_ready;
   logic [63:0] k1_in_dist;
   logic        k1_out_valid;
   logic        k1_out_ready;
   logic [0:0]  k1_out_idx;
   logic [63:0] k1_out_min_dist;

   int checks;
   int failures;
   int cyc;

   kmeans_argmin_select #(
      .DIST_W(64), .NUM_CLUSTERS(4), .IDX_W(2)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
`ifdef ARGMIN_TIE_FLAG_EN
      .out_tie(out_tie),
`endif
      .out_min_dist(out_min_dist)
   );

   kmeans_argmin_select #(
      .DIST_W(64), .NUM_CLUSTERS(1), .IDX_W(1)
   ) u_k1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(k1_in_valid), .in_ready(k1_in_ready),
      .in_dist(k1_in_dist),
      .out_valid(k1_out_valid), .out_ready(k1_out_ready),
      .out_idx(k1_out_idx),
`ifdef ARGMIN_TIE_FLAG_EN
      .out_tie(k1_out_tie),
`endif
      .out_min_dist(k1_out_min_dist)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one distance and hold it until accepted (bounded).
   task automatic send(input logic [63:0] d);
      int n;
      in_valid = 1'b1;
      in_dist  = d;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("send_timeout", 64'd1, 64'd0);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("out_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int c0;
      logic [63:0] max_d;
      checks = 0;
      failures = 0;
      cyc = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_dist = '0;
      out_ready = 1'b0;
      k1_in_valid = 1'b0;
      k1_in_dist = '0;
      k1_out_ready = 1'b1;
      step();
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_idx", 64'(out_idx), 64'd0);
      check("rst_out_min", out_min_dist, 64'd0);
`ifdef ARGMIN_TIE_FLAG_EN
      check("rst_out_tie", 64'(out_tie), 64'd0);
`endif
      rst_n = 1'b1;
      step();

      // 40,12,30,25 back-to-back with out_ready high
      out_ready = 1'b1;
      send(64'd40);
      send(64'd12);
      send(64'd30);
      send(64'd25);
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_idx", 64'(out_idx), 64'd1);
      check("t1_min", out_min_dist, 64'd12);
      check("t1_rdy_lo", 64'(in_ready), 64'd0);
      step();
      check("t1_rdy_hi", 64'(in_ready), 64'd1);
      check("t1_valid_lo", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // 7,7,3,3 then 9,5,8,6
      send(64'd7);
      send(64'd7);
      send(64'd3);
      send(64'd3);
      wait_out();
      check("t2a_idx", 64'(out_idx), 64'd2);
      check("t2a_min", out_min_dist, 64'd3);
`ifdef ARGMIN_TIE_FLAG_EN
      check("t2a_tie", 64'(out_tie), 64'd1);
`endif
      drain();
      send(64'd9);
      send(64'd5);
      send(64'd8);
      send(64'd6);
      wait_out();
      check("t2b_idx", 64'(out_idx), 64'd1);
      check("t2b_min", out_min_dist, 64'd5);
`ifdef ARGMIN_TIE_FLAG_EN
      check("t2b_tie", 64'(out_tie), 64'd0);
`endif
      drain();

      // all-max distances then max-1
      max_d = '1;
      send(max_d);
      send(max_d);
      send(max_d);
      send(max_d - 64'd1);
      wait_out();
      check("t3_idx", 64'(out_idx), 64'd3);
      check("t3_min", out_min_dist, 64'hFFFF_FFFF_FFFF_FFFE);
      drain();

      // all-equal gives index 0
      send(64'd11);
      send(64'd11);
      send(64'd11);
      send(64'd11);
      wait_out();
      check("teq_idx", 64'(out_idx), 64'd0);
      check("teq_min", out_min_dist, 64'd11);
      drain();

      // stall 10 cycles in HOLD, input pulses ignored
      send(64'd6);
      send(64'd2);
      send(64'd4);
      send(64'd9);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         in_dist  = 64'd1;
         step();
         check("t4_valid", 64'(out_valid), 64'd1);
         check("t4_idx", 64'(out_idx), 64'd1);
         check("t4_min", out_min_dist, 64'd2);
         check("t4_rdy", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      drain();
      send(64'd3);
      send(64'd8);
      send(64'd8);
      send(64'd8);
      wait_out();
      check("t4_next_idx", 64'(out_idx), 64'd0);
      check("t4_next_min", out_min_dist, 64'd3);
      drain();

      // 2-cycle gaps between 50,60,10,20
      c0 = cyc;
      send(64'd50);
      step(); step();
      send(64'd60);
      step(); step();
      send(64'd10);
      step(); step();
      send(64'd20);
      check("t5_cycles", 64'(cyc - c0), 64'd10);
      check("t5_valid", 64'(out_valid), 64'd1);
      check("t5_idx", 64'(out_idx), 64'd2);
      check("t5_min", out_min_dist, 64'd10);
      drain();

      // reset mid-point
      send(64'd1);
      send(64'd2);
      rst_n = 1'b0;
      #1;
      check("t6_valid", 64'(out_valid), 64'd0);
      check("t6_rdy", 64'(in_ready), 64'd1);
      check("t6_idx", 64'(out_idx), 64'd0);
      check("t6_min", out_min_dist, 64'd0);
      step();
      rst_n = 1'b1;
      step();
      send(64'd5);
      send(64'd4);
      send(64'd3);
      send(64'd9);
      wait_out();
      check("t6_idx2", 64'(out_idx), 64'd2);
      check("t6_min2", out_min_dist, 64'd3);
      drain();

      // K=1: each accept yields a result with idx 0
      k1_in_valid = 1'b1;
      k1_in_dist = 64'd77;
      step();
      k1_in_valid = 1'b0;
      check("k1a_valid", 64'(k1_out_valid), 64'd1);
      check("k1a_idx", 64'(k1_out_idx), 64'd0);
      check("k1a_min", k1_out_min_dist, 64'd77);
      step();
      check("k1a_rdy", 64'(k1_in_ready), 64'd1);
      k1_in_valid = 1'b1;
      k1_in_dist = 64'd3;
      step();
      k1_in_valid = 1'b0;
      check("k1b_valid", 64'(k1_out_valid), 64'd1);
      check("k1b_idx", 64'(k1_out_idx), 64'd0);
      check("k1b_min", k1_out_min_dist, 64'd3);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
